// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for a double-banked circular ADC sample buffer.
// Captures a pre/post-trigger window and hands finished banks to the readout via ready/valid.
module adc_capture_ctrl #(
  parameter int DEPTH = 11,
  parameter int DEL_W = 24,
  parameter int CH    = 2,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEL_W-1:0] sample_divider,
  input  logic [1:0]       mode,
  input  logic [DEPTH-1:0] pretrig,
  input  logic [TO_W-1:0]  auto_timeout,
  input  logic [CH-1:0]    ch_enable,
  input  logic             trigger_req,
  input  logic             arm,
  input  logic             ready,
  output logic             valid,
  output logic [DEPTH-1:0] mem_addr,
  output logic [CH-1:0]    mem_we,
  output logic             bank_sel,
  output logic [DEPTH-1:0] trig_addr,
  output logic             trig_bank,
  output logic             trig_forced,
  output logic [2:0]       state_o,
  output logic             triggered
);

  typedef enum logic [2:0] {
    PREBUF    = 3'd0,
    WAIT_TRIG = 3'd1,
    FILL      = 3'd2,
    WAIT_READ = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam int CW = DEPTH + 1;
  localparam logic [CW-1:0] N_SAMPLES = {1'b1, {DEPTH{1'b0}}};

  state_t           state;
  state_t           state_next;
  logic             started;
  logic [DEL_W-1:0] div_cnt;
  logic [CW-1:0]    sample_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [DEPTH-1:0] pre_lat;
  logic             trig_q;
  logic [DEPTH-1:0] trig_addr_int;
  logic             trig_bank_int;
  logic             forced_int;

  logic             tick;
  logic             timeout_hit;
  logic [CW-1:0]    pre_end;
  logic [CW-1:0]    fill_end;
  logic             take_trig;
  logic             take_forced;
  logic             handover;

  // The first cycle after reset never ticks, so no strobe leaks out while the bank restarts.
  assign tick        = started && (div_cnt == sample_divider);
  assign timeout_hit = (to_cnt == auto_timeout);
  assign pre_end     = {1'b0, pre_lat} - CW'(1);
  assign fill_end    = N_SAMPLES - {1'b0, pre_lat} - CW'(1);
  assign state_o     = state;

  always_comb begin
    state_next  = state;
    take_trig   = 1'b0;
    take_forced = 1'b0;
    handover    = 1'b0;
    valid       = (state == WAIT_READ);
    triggered   = (state == FILL);
    mem_we      = (tick && state != HALT) ? ch_enable : '0;

    case (state)
      PREBUF: begin
        if (pre_lat == '0 || (tick && sample_cnt == pre_end))
          state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        // A registered real trigger always beats an auto timeout in the same cycle.
        case (mode)
          2'd0, 2'd3: take_trig = trig_q;
          2'd1: begin
            if (trig_q) begin
              take_trig = 1'b1;
            end else if (timeout_hit) begin
              take_trig   = 1'b1;
              take_forced = 1'b1;
            end
          end
          default: take_trig = 1'b1;
        endcase
        if (take_trig)
          state_next = FILL;
      end
      FILL: begin
        if (tick && sample_cnt == fill_end)
          state_next = WAIT_READ;
      end
      WAIT_READ: begin
        if (ready) begin
          handover   = 1'b1;
          state_next = (mode == 2'd3) ? HALT : PREBUF;
        end
      end
      HALT: begin
        if (arm)
          state_next = PREBUF;
      end
      default: state_next = PREBUF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PREBUF;
      started       <= 1'b0;
      div_cnt       <= '0;
      sample_cnt    <= '0;
      to_cnt        <= '0;
      mem_addr      <= '0;
      bank_sel      <= 1'b0;
      trig_addr     <= '0;
      trig_bank     <= 1'b0;
      trig_forced   <= 1'b0;
      trig_addr_int <= '0;
      trig_bank_int <= 1'b0;
      forced_int    <= 1'b0;
      pre_lat       <= '0;
      trig_q        <= 1'b0;
    end else begin
      started <= 1'b1;
      trig_q  <= trigger_req;
      state   <= state_next;

      if (!started || tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DEL_W'(1);

      if (tick)
        mem_addr <= mem_addr + DEPTH'(1);

      if (state_next != state)
        sample_cnt <= '0;
      else if (tick)
        sample_cnt <= sample_cnt + CW'(1);

      if (state_next != state)
        to_cnt <= '0;
      else if (state == WAIT_TRIG && tick)
        to_cnt <= to_cnt + TO_W'(1);

      if (state_next == PREBUF && state != PREBUF)
        pre_lat <= pretrig;

      if (take_trig) begin
        trig_addr_int <= mem_addr;
        trig_bank_int <= bank_sel;
        forced_int    <= take_forced;
      end

      // Swapping banks here lets the reader take the finished bank while writing continues.
      if (handover) begin
        bank_sel    <= ~bank_sel;
        trig_addr   <= trig_addr_int;
        trig_bank   <= trig_bank_int;
        trig_forced <= forced_int;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl with a 16-sample bank (DEPTH=4).
// Each task drives one scenario and compares against hand-derived cycle timelines.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 4;
  localparam int DEL_W = 8;
  localparam int CH    = 2;
  localparam int TO_W  = 8;

  logic             clk;
  logic             rst;
  logic [DEL_W-1:0] sample_divider;
  logic [1:0]       mode;
  logic [DEPTH-1:0] pretrig;
  logic [TO_W-1:0]  auto_timeout;
  logic [CH-1:0]    ch_enable;
  logic             trigger_req;
  logic             arm;
  logic             ready;
  logic             valid;
  logic [DEPTH-1:0] mem_addr;
  logic [CH-1:0]    mem_we;
  logic             bank_sel;
  logic [DEPTH-1:0] trig_addr;
  logic             trig_bank;
  logic             trig_forced;
  logic [2:0]       state_o;
  logic             triggered;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  adc_capture_ctrl #(.DEPTH(DEPTH), .DEL_W(DEL_W), .CH(CH), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .sample_divider(sample_divider), .mode(mode),
    .pretrig(pretrig), .auto_timeout(auto_timeout), .ch_enable(ch_enable),
    .trigger_req(trigger_req), .arm(arm), .ready(ready), .valid(valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .bank_sel(bank_sel),
    .trig_addr(trig_addr), .trig_bank(trig_bank), .trig_forced(trig_forced),
    .state_o(state_o), .triggered(triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", mem_addr); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_bank: got %0d want 0", bank_sel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0d want 0", valid); end
    checks++; if (mem_we !== 2'b00) begin errors++; $display("[TB] FAIL reset_we: got %b want 00", mem_we); end
    checks++; if (trig_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    checks++; if (trig_forced !== 1'b0) begin errors++; $display("[TB] FAIL reset_forced: got %0d want 0", trig_forced); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL reset_triggered: got %0d want 0", triggered); end
    rst = 1'b0;
  endtask

  task automatic test_immediate();
    int fill = 0;
    int we = 0;
    mode = 2'd2;
    pretrig = 4'd4;
    step();
    checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL imm_wait_trig: got %0d want 1", state_o); end
    checks++; if (mem_we !== 2'b11) begin errors++; $display("[TB] FAIL imm_first_we: got %b want 11", mem_we); end
    step();
    checks++; if (triggered !== 1'b1) begin errors++; $display("[TB] FAIL imm_triggered: got %0d want 1", triggered); end
    while (state_o == 3'd2 && fill < 200) begin
      fill++;
      if (mem_we == 2'b11) we++;
      step();
    end
    checks++; if (fill != 16) begin errors++; $display("[TB] FAIL imm_fill_len: got %0d want 16", fill); end
    checks++; if (we != 16) begin errors++; $display("[TB] FAIL imm_fill_we: got %0d want 16", we); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL imm_valid: got %0d want 1", valid); end
    checks++; if (mem_addr !== 4'd1) begin errors++; $display("[TB] FAIL imm_addr: got %0d want 1", mem_addr); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    mode = 2'd0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL imm_next_state: got %0d want 0", state_o); end
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("[TB] FAIL imm_bank_sel: got %0d want 1", bank_sel); end
    checks++; if (trig_addr !== 4'd0) begin errors++; $display("[TB] FAIL imm_trig_addr: got %0d want 0", trig_addr); end
    checks++; if (trig_bank !== 1'b0) begin errors++; $display("[TB] FAIL imm_trig_bank: got %0d want 0", trig_bank); end
  endtask

  task automatic test_normal();
    int n = 0;
    int fill = 0;
    while (state_o == 3'd0 && n < 50) begin n++; step(); end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL norm_prebuf_len: got %0d want 4", n); end
    checks++; if (mem_addr !== 4'd6) begin errors++; $display("[TB] FAIL norm_wt_addr: got %0d want 6", mem_addr); end
    arm = 1'b1;
    step();
    arm = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL norm_arm_ignored: got %0d want 1", state_o); end
    step();
    step();
    checks++; if (mem_addr !== 4'd9) begin errors++; $display("[TB] FAIL norm_req_addr: got %0d want 9", mem_addr); end
    trigger_req = 1'b1;
    step();
    trigger_req = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL norm_accept_state: got %0d want 1", state_o); end
    checks++; if (mem_addr !== 4'd10) begin errors++; $display("[TB] FAIL norm_accept_addr: got %0d want 10", mem_addr); end
    step();
    while (state_o == 3'd2 && fill < 200) begin fill++; step(); end
    checks++; if (fill != 12) begin errors++; $display("[TB] FAIL norm_fill_len: got %0d want 12", fill); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL norm_valid: got %0d want 1", valid); end
    checks++; if (mem_addr !== 4'd7) begin errors++; $display("[TB] FAIL norm_wr_addr: got %0d want 7", mem_addr); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (trig_addr !== 4'd10) begin errors++; $display("[TB] FAIL norm_trig_addr: got %0d want 10", trig_addr); end
    checks++; if (trig_bank !== 1'b1) begin errors++; $display("[TB] FAIL norm_trig_bank: got %0d want 1", trig_bank); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("[TB] FAIL norm_bank_sel: got %0d want 0", bank_sel); end
  endtask

  task automatic test_auto();
    int n = 0;
    int wt = 0;
    int fill = 0;
    mode = 2'd1;
    auto_timeout = 8'd5;
    while (state_o == 3'd0 && n < 50) begin n++; step(); end
    checks++; if (mem_addr !== 4'd12) begin errors++; $display("[TB] FAIL auto_wt_addr: got %0d want 12", mem_addr); end
    while (state_o == 3'd1 && wt < 50) begin wt++; step(); end
    checks++; if (wt != 6) begin errors++; $display("[TB] FAIL auto_wait_len: got %0d want 6", wt); end
    while (state_o == 3'd2 && fill < 200) begin fill++; step(); end
    checks++; if (mem_addr !== 4'd14) begin errors++; $display("[TB] FAIL auto_wr_addr: got %0d want 14", mem_addr); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (trig_forced !== 1'b1) begin errors++; $display("[TB] FAIL auto_forced: got %0d want 1", trig_forced); end
    checks++; if (trig_addr !== 4'd1) begin errors++; $display("[TB] FAIL auto_trig_addr: got %0d want 1", trig_addr); end
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("[TB] FAIL auto_bank_sel: got %0d want 1", bank_sel); end
  endtask

  task automatic test_auto_race();
    int n = 0;
    int fill = 0;
    while (state_o == 3'd0 && n < 50) begin n++; step(); end
    checks++; if (mem_addr !== 4'd3) begin errors++; $display("[TB] FAIL race_wt_addr: got %0d want 3", mem_addr); end
    repeat (4) step();
    trigger_req = 1'b1;
    step();
    trigger_req = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL race_accept_state: got %0d want 1", state_o); end
    step();
    checks++; if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL race_fill: got %0d want 2", state_o); end
    while (state_o == 3'd2 && fill < 200) begin fill++; step(); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (trig_forced !== 1'b0) begin errors++; $display("[TB] FAIL race_forced: got %0d want 0", trig_forced); end
    checks++; if (trig_addr !== 4'd8) begin errors++; $display("[TB] FAIL race_trig_addr: got %0d want 8", trig_addr); end
    checks++; if (trig_bank !== 1'b1) begin errors++; $display("[TB] FAIL race_trig_bank: got %0d want 1", trig_bank); end
  endtask

  task automatic test_single();
    int n = 0;
    int fill = 0;
    int bad_we = 0;
    int bad_st = 0;
    mode = 2'd3;
    while (state_o == 3'd0 && n < 50) begin n++; step(); end
    checks++; if (mem_addr !== 4'd10) begin errors++; $display("[TB] FAIL single_wt_addr: got %0d want 10", mem_addr); end
    trigger_req = 1'b1;
    step();
    trigger_req = 1'b0;
    step();
    while (state_o == 3'd2 && fill < 200) begin fill++; step(); end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (state_o !== 3'd4) begin errors++; $display("[TB] FAIL single_halt: got %0d want 4", state_o); end
    checks++; if (trig_addr !== 4'd11) begin errors++; $display("[TB] FAIL single_trig_addr: got %0d want 11", trig_addr); end
    checks++; if (bank_sel !== 1'b1) begin errors++; $display("[TB] FAIL single_bank_sel: got %0d want 1", bank_sel); end
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_we !== 2'b00) bad_we++;
      if (state_o !== 3'd4) bad_st++;
    end
    checks++; if (bad_we != 0) begin errors++; $display("[TB] FAIL halt_we: got %0d strobes want 0", bad_we); end
    checks++; if (bad_st != 0) begin errors++; $display("[TB] FAIL halt_stay: got %0d exits want 0", bad_st); end
    arm = 1'b1;
    mode = 2'd2;
    pretrig = 4'd0;
    sample_divider = 8'd3;
    step();
    arm = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL arm_prebuf: got %0d want 0", state_o); end
  endtask

  task automatic test_divider();
    int fill = 0;
    int we = 0;
    int bad = 0;
    int last = -1;
    step();
    checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL div_wait_trig: got %0d want 1", state_o); end
    step();
    while (state_o == 3'd2 && fill < 300) begin
      fill++;
      if (mem_we != 2'b00) begin
        we++;
        if (last >= 0 && cyc - last != 4) bad++;
        last = cyc;
      end
      step();
    end
    checks++; if (fill != 61) begin errors++; $display("[TB] FAIL div_fill_len: got %0d want 61", fill); end
    checks++; if (we != 16) begin errors++; $display("[TB] FAIL div_we_count: got %0d want 16", we); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL div_we_spacing: got %0d bad gaps want 0", bad); end
    checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL div_wait_read: got %0d want 3", state_o); end
  endtask

  task automatic test_ready_held();
    int bad = 0;
    int we0 = 0;
    int we1 = 0;
    int nwr = 0;
    logic [2:0] prev_state;
    logic prev_bank;
    ready = 1'b1;
    ch_enable = 2'b01;
    sample_divider = 8'd0;
    pretrig = 4'd0;
    prev_state = state_o;
    prev_bank = bank_sel;
    for (int i = 0; i < 60; i++) begin
      step();
      if ((bank_sel != prev_bank) != (prev_state == 3'd3)) bad++;
      if (mem_we[1]) we1++;
      if (mem_we[0]) we0++;
      if (state_o == 3'd3) nwr++;
      prev_state = state_o;
      prev_bank = bank_sel;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL held_swap_timing: got %0d bad swaps want 0", bad); end
    checks++; if (we1 != 0) begin errors++; $display("[TB] FAIL held_we1: got %0d strobes want 0", we1); end
    checks++; if (we0 == 0) begin errors++; $display("[TB] FAIL held_we0: got %0d strobes want nonzero", we0); end
    checks++; if (nwr != 3) begin errors++; $display("[TB] FAIL held_wr_cycles: got %0d want 3", nwr); end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    while (!(state_o == 3'd2 && bank_sel == 1'b1) && n < 100) begin n++; step(); end
    checks++; if (n >= 100) begin errors++; $display("[TB] FAIL midfill_reach: got %0d cycles want below 100", n); end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL midfill_state: got %0d want 0", state_o); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("[TB] FAIL midfill_addr: got %0d want 0", mem_addr); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("[TB] FAIL midfill_bank: got %0d want 0", bank_sel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midfill_valid: got %0d want 0", valid); end
    checks++; if (mem_we !== 2'b00) begin errors++; $display("[TB] FAIL midfill_we: got %b want 00", mem_we); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("[TB] FAIL midfill_triggered: got %0d want 0", triggered); end
  endtask

  initial begin
    rst = 1'b1;
    sample_divider = '0;
    mode = 2'd0;
    pretrig = '0;
    auto_timeout = '0;
    ch_enable = 2'b11;
    trigger_req = 1'b0;
    arm = 1'b0;
    ready = 1'b0;
    test_reset();
    test_immediate();
    test_normal();
    test_auto();
    test_auto_race();
    test_single();
    test_divider();
    test_ready_held();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
